// File: rtl/matrix_frame_rx.sv
// -----------------------------------------------------------------------------
// matrix_frame_rx
//
// Framing stage between the UART receiver and the 2x2 matrix-multiply core.
// Hunts for SYNC_BYTE, collects PAYLOAD_BYTES payload bytes (A0..A3, B0..B3),
// then compares the next byte against the XOR of the payload. A good frame is
// replayed to the core as a valid/ready burst. A bad frame is dropped, so a
// lost or corrupt UART byte can never shift the core's operand counter.
//
// Parameters
//   PAYLOAD_BYTES  payload bytes per frame (core operand count)
//   SYNC_BYTE      frame start marker, only recognised while hunting
//   TIMEOUT_CLKS   idle-clock limit inside a frame (FRAME_RX_TIMEOUT_EN only)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_byte    in   byte from UART receiver
//   in_valid   in   1-cycle strobe qualifying in_byte (no backpressure)
//   out_byte   out  payload byte to the core
//   out_valid  out  out_byte valid, held until accepted
//   out_ready  in   core accepts out_byte when out_valid && out_ready
//   out_last   out  marks the final payload byte of the burst
//   frame_ok   out  1-cycle pulse: checksum matched, burst starts next cycle
//   frame_err  out  1-cycle pulse: checksum mismatch or idle timeout
//   overrun    out  1-cycle pulse: byte arrived while draining and was dropped
//   busy       out  high whenever not hunting for a sync byte
//
// Configuration macro
//   FRAME_RX_TIMEOUT_EN  when defined, adds a 16-bit idle counter that aborts a
//                        frame after TIMEOUT_CLKS clocks without a byte. When
//                        undefined, a partial frame waits indefinitely.
// -----------------------------------------------------------------------------
module matrix_frame_rx #(
   parameter int unsigned PAYLOAD_BYTES = 8,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
`ifdef FRAME_RX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CLKS  = 1000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_byte,
   input  logic       in_valid,
   output logic [7:0] out_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned      IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_CHECK   = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_nxt_s;
   logic [7:0]       csum_r;
   logic [7:0]       payload_r [PAYLOAD_BYTES];
   logic             pay_we_s;
   logic             timeout_hit_s;

   // Running XOR checksum over payload bytes.
   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

   assign idx_nxt_s = idx_r + IDX_ONE;
   assign pay_we_s  = (state_r == S_PAYLOAD) && in_valid;
   assign busy      = (state_r != S_HUNT);

`ifdef FRAME_RX_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

   logic [15:0] idle_cnt_r;

   // The counter fires on the clock that would carry it to TIMEOUT_CLKS.
   assign timeout_hit_s = ((state_r == S_PAYLOAD) || (state_r == S_CHECK)) &&
                          !in_valid && (idle_cnt_r == TO_LAST);

   // Idle counter: runs only while waiting for bytes inside a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_r <= 16'd0;
      end else if (((state_r == S_PAYLOAD) || (state_r == S_CHECK)) &&
                   !in_valid && !timeout_hit_s) begin
         idle_cnt_r <= idle_cnt_r + 16'd1;
      end else begin
         idle_cnt_r <= 16'd0;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Payload buffer: plain storage, contents are meaningless until a frame lands.
   always_ff @(posedge clk) begin
      if (pay_we_s) begin
         payload_r[idx_r] <= in_byte;
      end
   end

   // Frame FSM with registered burst outputs and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_HUNT;
         idx_r     <= IDX_ZERO;
         csum_r    <= 8'h00;
         out_byte  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         case (state_r)
            S_HUNT: begin
               if (in_valid && (in_byte == SYNC_BYTE)) begin
                  state_r <= S_PAYLOAD;
                  idx_r   <= IDX_ZERO;
                  csum_r  <= 8'h00;
               end
            end

            // SYNC_BYTE is ordinary data here; there is no escaping.
            S_PAYLOAD: begin
               if (in_valid) begin
                  csum_r <= csum_update(csum_r, in_byte);
                  if (idx_r == LAST_IDX) begin
                     idx_r   <= IDX_ZERO;
                     state_r <= S_CHECK;
                  end else begin
                     idx_r <= idx_nxt_s;
                  end
               end else if (timeout_hit_s) begin
                  frame_err <= 1'b1;
                  state_r   <= S_HUNT;
               end
            end

            S_CHECK: begin
               if (in_valid) begin
                  if (in_byte == csum_r) begin
                     frame_ok <= 1'b1;
                     idx_r    <= IDX_ZERO;
                     state_r  <= S_DRAIN;
                  end else begin
                     frame_err <= 1'b1;
                     state_r   <= S_HUNT;
                  end
               end else if (timeout_hit_s) begin
                  frame_err <= 1'b1;
                  state_r   <= S_HUNT;
               end
            end

            // First drain cycle loads beat 0, which places out_valid one clock
            // after the frame_ok pulse. Later beats are preloaded on each
            // handshake so a ready core sees one byte per clock.
            S_DRAIN: begin
               if (in_valid) begin
                  overrun <= 1'b1;
               end
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_byte  <= payload_r[idx_r];
                  out_last  <= (idx_r == LAST_IDX);
               end else if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     idx_r     <= IDX_ZERO;
                     state_r   <= S_HUNT;
                  end else begin
                     idx_r    <= idx_nxt_s;
                     out_byte <= payload_r[idx_nxt_s];
                     out_last <= (idx_nxt_s == LAST_IDX);
                  end
               end
            end

            default: begin
               state_r   <= S_HUNT;
               idx_r     <= IDX_ZERO;
               csum_r    <= 8'h00;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_matrix_frame_rx
//
// Self-checking bench for matrix_frame_rx. Frames are built by the bench with
// a known shape (junk, sync, payload, checksum), so the expected outcome of
// each frame follows directly from how it was constructed: good checksum gives
// a burst equal to the payload, bad checksum gives a frame_err and no beats.
// A negedge monitor collects accepted beats and checks handshake rules.
// -----------------------------------------------------------------------------
module tb_matrix_frame_rx;

   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk;
   logic       rst;
   logic [7:0] in_byte;
   logic       in_valid;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         n_checks = 0;
   int         n_errors = 0;
   int         rdy_mode = 1;
   string      cur_test = "reset";

   logic [7:0] junk_q [$];
   logic [7:0] pay [8];
   logic [7:0] cs_byte;
   logic [7:0] got_q [$];

   logic       stall_prev = 1'b0;
   logic [7:0] prev_byte  = 8'h00;
   logic       prev_last  = 1'b0;
   int         pulses;

`ifdef FRAME_RX_TIMEOUT_EN
   matrix_frame_rx #(.TIMEOUT_CLKS(20)) dut (
`else
   matrix_frame_rx dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s %s: got 0x%0h expected 0x%0h", cur_test, tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      in_byte  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
   endtask

   // Ready pattern driver: 0 stall, 1 always ready, 2 toggle, 3 random.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pulse exclusivity, stall stability, beat capture and out_last.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         pulses = int'(frame_ok) + int'(frame_err) + int'(overrun);
         chk_eq("one_pulse", 32'(pulses <= 1), 32'd1);
         if (stall_prev) begin
            chk_eq("hold_valid", 32'(out_valid), 32'd1);
            chk_eq("hold_byte", 32'(out_byte), 32'(prev_byte));
            chk_eq("hold_last", 32'(out_last), 32'(prev_last));
         end
         if (out_valid && out_ready) begin
            chk_eq("out_last", 32'(out_last), 32'(got_q.size() == 7));
            got_q.push_back(out_byte);
         end
         stall_prev = out_valid && !out_ready;
         prev_byte  = out_byte;
         prev_last  = out_last;
      end
   end

   task automatic finish_burst();
      int n;
      n = 0;
      while (busy && (n < 400)) begin
         tick();
         n++;
      end
      chk_eq("drain_done", 32'(busy), 32'd0);
      chk_eq("beat_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size()) begin
            chk_eq("beat_data", 32'(got_q[i]), 32'(pay[i]));
         end
      end
   endtask

   // Sends junk_q, sync, pay[] and cs_byte, then checks the frame verdict.
   task automatic run_frame(input int max_gap, input bit wait_drain);
      logic [7:0] exp_cs;
      bit         exp_ok;
      got_q.delete();
      foreach (junk_q[i]) begin
         send_byte(junk_q[i], int'($urandom_range(0, max_gap)));
         chk_eq("junk_busy", 32'(busy), 32'd0);
      end
      send_byte(SYNC, int'($urandom_range(0, max_gap)));
      chk_eq("sync_busy", 32'(busy), 32'd1);
      exp_cs = 8'h00;
      for (int i = 0; i < 8; i++) begin
         send_byte(pay[i], int'($urandom_range(0, max_gap)));
         exp_cs = exp_cs ^ pay[i];
      end
      chk_eq("pay_busy", 32'(busy), 32'd1);
      send_byte(cs_byte, int'($urandom_range(0, max_gap)));
      exp_ok = (cs_byte == exp_cs);
      chk_eq("frame_ok", 32'(frame_ok), 32'(exp_ok));
      chk_eq("frame_err", 32'(frame_err), 32'(!exp_ok));
      chk_eq("valid_early", 32'(out_valid), 32'd0);
      tick();
      chk_eq("ok_pulse_end", 32'(frame_ok), 32'd0);
      chk_eq("err_pulse_end", 32'(frame_err), 32'd0);
      chk_eq("first_valid", 32'(out_valid), 32'(exp_ok));
      if (exp_ok) begin
         chk_eq("first_byte", 32'(out_byte), 32'(pay[0]));
         if (wait_drain) finish_burst();
      end else begin
         chk_eq("err_busy", 32'(busy), 32'd0);
         repeat (3) tick();
         chk_eq("err_no_valid", 32'(out_valid), 32'd0);
         chk_eq("err_no_beats", 32'(got_q.size()), 32'd0);
      end
   endtask

   task automatic make_random_frame(input bit bad);
      logic [7:0] x;
      logic [7:0] j;
      junk_q.delete();
      repeat ($urandom_range(0, 3)) begin
         j = 8'($urandom);
         while (j == SYNC) j = 8'($urandom);
         junk_q.push_back(j);
      end
      x = 8'h00;
      for (int i = 0; i < 8; i++) begin
         pay[i] = 8'($urandom);
         x      = x ^ pay[i];
      end
      cs_byte = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
   endtask

   task automatic check_all_zero();
      chk_eq("rst_out_byte", 32'(out_byte), 32'd0);
      chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_out_last", 32'(out_last), 32'd0);
      chk_eq("rst_frame_ok", 32'(frame_ok), 32'd0);
      chk_eq("rst_frame_err", 32'(frame_err), 32'd0);
      chk_eq("rst_overrun", 32'(overrun), 32'd0);
      chk_eq("rst_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      repeat (3) tick();
      check_all_zero();
      rst = 1'b0;
      tick();

      // Test 1: counting frame, ready held high, one byte per clock.
      cur_test = "t1";
      rdy_mode = 1;
      tick();
      junk_q.delete();
      for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
      cs_byte = 8'h08;
      run_frame(0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk_eq("t1_valid", 32'(out_valid), 32'd1);
         chk_eq("t1_byte", 32'(out_byte), 32'(i + 1));
         chk_eq("t1_last", 32'(out_last), 32'(i == 7));
         tick();
      end
      chk_eq("t1_end_valid", 32'(out_valid), 32'd0);
      chk_eq("t1_end_busy", 32'(busy), 32'd0);
      chk_eq("t1_beats", 32'(got_q.size()), 32'd8);

      // Test 2: same frame with ready toggling every clock.
      cur_test = "t2";
      rdy_mode = 2;
      run_frame(1, 1'b1);

      // Test 3: wrong checksum byte.
      cur_test = "t3";
      rdy_mode = 1;
      cs_byte  = 8'hFF;
      run_frame(0, 1'b1);

      // Test 4: junk before sync, sync value as the first payload byte.
      cur_test = "t4";
      junk_q.delete();
      junk_q.push_back(8'h3C);
      junk_q.push_back(8'h77);
      pay[0] = 8'hA5;
      for (int i = 1; i < 8; i++) pay[i] = 8'h00;
      cs_byte = 8'hA5;
      run_frame(0, 1'b1);

      // Test 5a: byte arriving during a stalled drain is dropped.
      cur_test = "t5_overrun";
      rdy_mode = 0;
      make_random_frame(1'b0);
      run_frame(1, 1'b0);
      repeat (2) tick();
      send_byte(8'h42, 0);
      chk_eq("ovr_pulse", 32'(overrun), 32'd1);
      chk_eq("ovr_valid", 32'(out_valid), 32'd1);
      chk_eq("ovr_byte", 32'(out_byte), 32'(pay[0]));
      chk_eq("ovr_busy", 32'(busy), 32'd1);
      tick();
      chk_eq("ovr_pulse_end", 32'(overrun), 32'd0);
      rdy_mode = 3;
      finish_burst();

      // Test 5b: reset in the middle of a payload.
      cur_test = "t5_rst_payload";
      rdy_mode = 1;
      send_byte(SYNC, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      send_byte(8'h33, 0);
      chk_eq("mid_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero();
      tick();
      rst = 1'b0;
      make_random_frame(1'b0);
      run_frame(2, 1'b1);

      // Test 5c: reset during a stalled burst abandons it.
      cur_test = "t5_rst_drain";
      rdy_mode = 0;
      make_random_frame(1'b0);
      run_frame(0, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      check_all_zero();
      tick();
      rst      = 1'b0;
      rdy_mode = 3;
      make_random_frame(1'b0);
      run_frame(1, 1'b1);

`ifdef FRAME_RX_TIMEOUT_EN
      // Test 6: idle inside a frame aborts it, next frame still accepted.
      cur_test = "t6";
      rdy_mode = 1;
      send_byte(SYNC, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      repeat (19) tick();
      chk_eq("to_not_yet", 32'(frame_err), 32'd0);
      chk_eq("to_busy", 32'(busy), 32'd1);
      tick();
      chk_eq("to_err", 32'(frame_err), 32'd1);
      chk_eq("to_hunt", 32'(busy), 32'd0);
      tick();
      chk_eq("to_err_end", 32'(frame_err), 32'd0);
      make_random_frame(1'b0);
      run_frame(2, 1'b1);
`endif

      // Randomized frames: random junk, payload, gaps, ready pattern, errors.
      cur_test = "random";
      for (int f = 0; f < 40; f++) begin
         rdy_mode = int'($urandom_range(1, 3));
         make_random_frame($urandom_range(0, 2) == 0);
         run_frame(3, 1'b1);
      end

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
